// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined core.
// Owns the PC, issues one outstanding instruction-memory request at a time
// and loads the IF/ID register (pc_f, pc_plus4_f, instr_f, instr_valid_f).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall_f, stall_d, flush_d hazard-unit controls
//   pc_src_e, pc_target_e     execute-stage redirect
//   imem_req_*                request channel (valid/ready), addr = pc_reg
//   imem_resp_*               response channel (valid-only pulse)
//   pc_f, pc_plus4_f, instr_f, instr_valid_f   IF/ID register
//   fetch_busy                a request is outstanding
module fetch_stage #(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_resp_data,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic                     instr_valid_f,
  output logic                     fetch_busy
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDRESS_WIDTH-1:0] pc_reg_plus4;
  logic                     discard, discard_next;
  logic [ADDRESS_WIDTH-1:0] hold_pc;
  logic [DATA_WIDTH-1:0]    hold_data;

  logic kill;
  logic req_fire;
  logic load_mem;
  logic load_buf;
  logic buf_capture;

  assign pc_reg_plus4 = pc_reg + ADDRESS_WIDTH'(4);
  assign kill         = pc_src_e | flush_d;
  assign req_fire     = imem_req_valid & imem_req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc_reg  <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_next;
      pc_reg  <= pc_next;
      discard <= discard_next;
    end
  end

  // Next-state logic; the redirect target overrides any PC update last
  always_comb begin
    state_next   = state;
    pc_next      = pc_reg;
    discard_next = discard;
    load_mem     = 1'b0;
    load_buf     = 1'b0;
    buf_capture  = 1'b0;
    case (state)
      S_REQ: begin
        if (req_fire) begin
          state_next = S_WAIT;
          // request already left with the old address; its data is stale
          if (pc_src_e) discard_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_next = S_REQ;
          if (discard) begin
            discard_next = 1'b0;
          end else if (!kill) begin
            if (!stall_d) begin
              load_mem = 1'b1;
              pc_next  = pc_reg_plus4;
            end else begin
              buf_capture = 1'b1;
              state_next  = S_HOLD;
            end
          end
        end else if (pc_src_e) begin
          discard_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (kill) begin
          state_next = S_REQ;
        end else if (!stall_d) begin
          load_buf   = 1'b1;
          pc_next    = pc_reg_plus4;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
    if (pc_src_e) pc_next = pc_target_e;
  end

  // Outputs
  always_comb begin
    imem_req_valid = (state == S_REQ) & ~stall_f & ~rst;
    imem_req_addr  = pc_reg;
    fetch_busy     = (state == S_WAIT);
  end

  // Hold buffer: a response that arrived while decode was stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc   <= '0;
      hold_data <= '0;
    end else if (buf_capture) begin
      hold_pc   <= pc_reg;
      hold_data <= imem_resp_data;
    end
  end

  // IF/ID register; holds its contents unless reset, bubbled or loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f          <= RESET_PC;
      pc_plus4_f    <= RESET_PC + ADDRESS_WIDTH'(4);
      instr_f       <= NOP_INSTR;
      instr_valid_f <= 1'b0;
    end else if (kill) begin
      instr_f       <= NOP_INSTR;
      instr_valid_f <= 1'b0;
    end else if (load_mem) begin
      pc_f          <= pc_reg;
      pc_plus4_f    <= pc_reg_plus4;
      instr_f       <= imem_resp_data;
      instr_valid_f <= 1'b1;
    end else if (load_buf) begin
      pc_f          <= hold_pc;
      pc_plus4_f    <= hold_pc + ADDRESS_WIDTH'(4);
      instr_f       <= hold_data;
      instr_valid_f <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: two instances (default reset PC and a reset PC
// at the top of the address space) share the hazard/redirect stimulus, each
// with its own instruction-memory model and fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_f, stall_d, flush_d, pc_src_e, ready;
  logic [31:0] target;

  logic        req_v  [2];
  logic [31:0] req_a  [2];
  logic        resp_v [2];
  logic [31:0] resp_d [2];
  logic [31:0] pcf    [2];
  logic [31:0] pc4    [2];
  logic [31:0] ins    [2];
  logic        iv     [2];
  logic        busy   [2];

  int n_err = 0;
  int n_chk = 0;
  int lat   = 1;

  // memory model state
  bit          mp    [2];
  int          mrem  [2];
  logic [31:0] maddr [2];

  // fetch model state
  bit          m_ok = 1'b0;
  logic [31:0] m_pc   [2];
  bit          m_out  [2];
  bit          m_drop [2];
  bit          m_held [2];
  logic [31:0] m_hpc  [2];
  logic [31:0] m_hdat [2];
  logic [31:0] m_pcf  [2];
  logic [31:0] m_pc4  [2];
  logic [31:0] m_ins  [2];
  bit          m_iv   [2];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(target),
    .imem_req_valid(req_v[0]), .imem_req_ready(ready), .imem_req_addr(req_a[0]),
    .imem_resp_valid(resp_v[0]), .imem_resp_data(resp_d[0]),
    .pc_f(pcf[0]), .pc_plus4_f(pc4[0]), .instr_f(ins[0]),
    .instr_valid_f(iv[0]), .fetch_busy(busy[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(target),
    .imem_req_valid(req_v[1]), .imem_req_ready(ready), .imem_req_addr(req_a[1]),
    .imem_resp_valid(resp_v[1]), .imem_resp_data(resp_d[1]),
    .pc_f(pcf[1]), .pc_plus4_f(pc4[1]), .instr_f(ins[1]),
    .instr_valid_f(iv[1]), .fetch_busy(busy[1])
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0010_0093;
      32'h0000_0004: mem_word = 32'h0020_0113;
      default:       mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  function automatic logic [31:0] reset_pc(input int i);
    reset_pc = (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_load(input int i, input logic [31:0] pc, input logic [31:0] d);
    m_pcf[i] = pc;
    m_pc4[i] = pc + 32'd4;
    m_ins[i] = d;
    m_iv[i]  = 1'b1;
  endtask

  task automatic model_step(input int i);
    bit kill, issue, got;
    if (rst) begin
      m_pc[i] = reset_pc(i);
      m_out[i] = 0; m_drop[i] = 0; m_held[i] = 0;
      m_pcf[i] = reset_pc(i);
      m_pc4[i] = reset_pc(i) + 32'd4;
      m_ins[i] = NOP;
      m_iv[i]  = 0;
      return;
    end
    kill  = pc_src_e || flush_d;
    issue = !m_out[i] && !m_held[i] && !stall_f && ready;
    got   = resp_v[i] && m_out[i];
    if (kill) begin
      m_ins[i] = NOP;
      m_iv[i]  = 0;
    end
    if (m_held[i]) begin
      if (kill) m_held[i] = 0;
      else if (!stall_d) begin
        model_load(i, m_hpc[i], m_hdat[i]);
        m_pc[i]   = m_pc[i] + 32'd4;
        m_held[i] = 0;
      end
    end else if (got) begin
      m_out[i] = 0;
      if (m_drop[i]) m_drop[i] = 0;
      else if (!kill) begin
        if (!stall_d) begin
          model_load(i, m_pc[i], resp_d[i]);
          m_pc[i] = m_pc[i] + 32'd4;
        end else begin
          m_held[i] = 1;
          m_hpc[i]  = m_pc[i];
          m_hdat[i] = resp_d[i];
        end
      end
    end
    if (issue) m_out[i] = 1;
    if (pc_src_e) begin
      m_pc[i] = target;
      if (m_out[i]) m_drop[i] = 1;
    end
  endtask

  // One clock cycle: drive memory responses, compare, advance models.
  task automatic tick();
    bit acc [2];
    for (int i = 0; i < 2; i++) begin
      if (mp[i] && mrem[i] == 0) begin
        resp_v[i] = 1'b1;
        resp_d[i] = mem_word(maddr[i]);
        mp[i] = 0;
      end else begin
        resp_v[i] = 1'b0;
        resp_d[i] = 32'hDEAD_BEEF;
        if (mp[i]) mrem[i]--;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_ok) begin
        chk($sformatf("u%0d.req_valid", i), 32'(req_v[i]),
            32'(!rst && !m_out[i] && !m_held[i] && !stall_f));
        chk($sformatf("u%0d.req_addr", i), req_a[i], m_pc[i]);
        chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_out[i]));
        chk($sformatf("u%0d.pc_f", i), pcf[i], m_pcf[i]);
        chk($sformatf("u%0d.pc_plus4_f", i), pc4[i], m_pc4[i]);
        chk($sformatf("u%0d.instr_f", i), ins[i], m_ins[i]);
        chk($sformatf("u%0d.instr_valid_f", i), 32'(iv[i]), 32'(m_iv[i]));
      end
      acc[i] = req_v[i] && ready;
      model_step(i);
      if (acc[i]) begin
        mp[i]    = 1;
        mrem[i]  = lat - 1;
        maddr[i] = req_a[i];
      end
    end
    if (rst) m_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
    ready = 1; target = '0;
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mrem[i] = 0; maddr[i] = '0;
      resp_v[i] = 0; resp_d[i] = '0;
    end
    @(negedge clk);
    ticks(2);
    rst = 0;
    #1;
    chk("rst.pc_f", pcf[0], 32'h0);
    chk("rst.pc_plus4_f", pc4[0], 32'h4);
    chk("rst.instr_f", ins[0], NOP);
    chk("rst.valid", 32'(iv[0]), 32'h0);
    chk("rst.req_valid", 32'(req_v[0]), 32'h1);
    chk("rst_top.pc_plus4_f", pc4[1], 32'h0);
    chk("rst_top.req_addr", req_a[1], 32'hFFFF_FFFC);

    // two back-to-back fetches
    ticks(2);
    chk("f0.pc_f", pcf[0], 32'h0);
    chk("f0.instr_f", ins[0], 32'h0010_0093);
    chk("f0.valid", 32'(iv[0]), 32'h1);
    chk("f0.req_addr", req_a[0], 32'h4);
    chk("wrap.pc_f", pcf[1], 32'hFFFF_FFFC);
    chk("wrap.pc_plus4_f", pc4[1], 32'h0);
    chk("wrap.instr_f", ins[1], 32'h5A5A_FFFC);
    chk("wrap.req_addr", req_a[1], 32'h0);
    ticks(2);
    chk("f4.pc_f", pcf[0], 32'h4);
    chk("f4.pc_plus4_f", pc4[0], 32'h8);
    chk("f4.instr_f", ins[0], 32'h0020_0113);
    chk("f4.req_addr", req_a[0], 32'h8);

    // decode stall across the addr-8 response
    tick();
    stall_d = 1;
    ticks(3);
    chk("hold.busy", 32'(busy[0]), 32'h0);
    chk("hold.req_valid", 32'(req_v[0]), 32'h0);
    chk("hold.pc_f", pcf[0], 32'h4);
    stall_d = 0;
    tick();
    chk("rel.pc_f", pcf[0], 32'h8);
    chk("rel.instr_f", ins[0], 32'hA5A5_0008);
    chk("rel.req_addr", req_a[0], 32'hC);

    // redirect while waiting on addr 12
    lat = 3;
    tick();
    pc_src_e = 1; target = 32'h40;
    tick();
    pc_src_e = 0;
    chk("redir.busy", 32'(busy[0]), 32'h1);
    chk("redir.pc_f", pcf[0], 32'h8);
    chk("redir.instr_f", ins[0], NOP);
    chk("redir.valid", 32'(iv[0]), 32'h0);
    chk("redir.req_addr", req_a[0], 32'h40);
    ticks(2);
    chk("disc.busy", 32'(busy[0]), 32'h0);
    chk("disc.valid", 32'(iv[0]), 32'h0);
    chk("disc.req_addr", req_a[0], 32'h40);

    // flush in the response cycle: same PC refetched
    lat = 1;
    tick();
    flush_d = 1;
    tick();
    flush_d = 0;
    chk("flush.req_addr", req_a[0], 32'h40);
    chk("flush.valid", 32'(iv[0]), 32'h0);
    ticks(2);
    chk("refetch.pc_f", pcf[0], 32'h40);
    chk("refetch.pc_plus4_f", pc4[0], 32'h44);
    chk("refetch.instr_f", ins[0], 32'hA5A5_0040);
    chk("refetch.req_addr", req_a[0], 32'h44);

    // fetch stall, then memory not ready
    stall_f = 1;
    ticks(3);
    chk("stallf.req_valid", 32'(req_v[0]), 32'h0);
    chk("stallf.req_addr", req_a[0], 32'h44);
    stall_f = 0; ready = 0;
    ticks(4);
    chk("nrdy.req_addr", req_a[0], 32'h44);
    chk("nrdy.busy", 32'(busy[0]), 32'h0);
    chk("nrdy.req_valid", 32'(req_v[0]), 32'h1);
    ready = 1;

    // redirect in the same cycle as a handshake
    pc_src_e = 1; target = 32'h80;
    tick();
    pc_src_e = 0;
    chk("rhs.busy", 32'(busy[0]), 32'h1);
    chk("rhs.req_addr", req_a[0], 32'h80);
    tick();
    chk("rhs.drop_busy", 32'(busy[0]), 32'h0);
    ticks(2);
    chk("rhs.pc_f", pcf[0], 32'h80);
    chk("rhs.instr_f", ins[0], 32'hA5A5_0080);

    // redirect while holding a stalled response
    stall_d = 1;
    ticks(2);
    chk("hold2.pc_f", pcf[0], 32'h80);
    chk("hold2.busy", 32'(busy[0]), 32'h0);
    pc_src_e = 1; target = 32'hC0;
    tick();
    pc_src_e = 0; stall_d = 0;
    chk("hredir.req_addr", req_a[0], 32'hC0);
    chk("hredir.valid", 32'(iv[0]), 32'h0);

    // reset while a request is outstanding; late response arrives afterwards
    lat = 3;
    ticks(2);
    chk("wrst.busy", 32'(busy[0]), 32'h1);
    rst = 1;
    tick();
    rst = 0; stall_f = 1;
    #1;
    chk("wrst.pc_f", pcf[0], 32'h0);
    chk("wrst.instr_f", ins[0], NOP);
    chk("wrst.busy", 32'(busy[0]), 32'h0);
    chk("wrst.req_addr", req_a[0], 32'h0);
    ticks(2);
    chk("late.valid", 32'(iv[0]), 32'h0);
    chk("late.busy", 32'(busy[0]), 32'h0);
    stall_f = 0; lat = 1;
    ticks(2);
    chk("post.pc_f", pcf[0], 32'h0);
    chk("post.instr_f", ins[0], 32'h0010_0093);
    ticks(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
